// File: rtl/param_updown_counter_pkg.sv
// param_counter_pkg
//   Shared definitions for the parameterised up/down counter:
//   - MODE_* : encodings of the 2-bit mode input (2'b11 behaves as WRAP)
//   - state_t: count FSM states (RUN counts, DONE parks after a ONESHOT)
package param_counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

endpackage

// File: rtl/cnt_prescaler.sv
// cnt_prescaler
//   Divides enabled cycles: tick is high on every (pre_div+1)-th cycle with en=1.
//   Ports:
//     clk     - clock, rising edge
//     reset   - synchronous, active-high; clears the divider count
//     en      - count enable; en=0 holds the divider count
//     clr     - synchronous clear of the divider count (used on load)
//     pre_div - divisor minus one
//     tick    - high during the enabled cycle on which the count matches pre_div
import param_counter_pkg::*;

module cnt_prescaler #(
    parameter int unsigned PRE_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [PRE_W-1:0] pre_div,
    output logic             tick
);

    logic [PRE_W-1:0] pre_cnt;

    // Decoded from the registered count so the parent can act in the same cycle.
    assign tick = en && (pre_cnt == pre_div);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// param_updown_counter
//   Prescaled up/down counter with WRAP, SAT and ONESHOT terminal behaviour.
//   Ports:
//     clk      - clock, rising edge
//     reset    - synchronous, active-high
//     en       - count enable (gates the prescaler)
//     dir      - 0 up, 1 down
//     mode     - 00 WRAP, 01 SAT, 10 ONESHOT, 11 WRAP
//     load     - synchronous load strobe, overrides a coincident tick
//     load_val - value to load, clipped to max_val
//     max_val  - up-count terminal value
//     pre_div  - prescaler divisor minus one
//     q        - registered count
//     tc       - one-cycle pulse after q is written with the terminal value
//     done     - level, set when a ONESHOT reaches terminal
//     ovf      - sticky wrap flag, cleared by load or reset
import param_counter_pkg::*;

module param_updown_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PRE_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic [PRE_W-1:0] pre_div,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             done,
    output logic             ovf
);

    state_t           state;
    logic             tick;
    logic [WIDTH-1:0] load_clip;
    logic [WIDTH-1:0] q_next;
    logic             at_term;
    logic             reach_term;

    cnt_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .clr     (load),
        .pre_div (pre_div),
        .tick    (tick)
    );

    always_comb begin
        load_clip  = (load_val > max_val) ? max_val : load_val;
        q_next     = dir ? (q - 1'b1) : (q + 1'b1);
        // Up terminal uses >= so a runtime-lowered max_val still terminates.
        at_term    = dir ? (q == '0) : (q >= max_val);
        reach_term = dir ? (q_next == '0) : (q_next == max_val);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q     <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
            ovf   <= 1'b0;
            state <= RUN;
        end else begin
            tc <= 1'b0;
            if (load) begin
                q     <= load_clip;
                ovf   <= 1'b0;
                done  <= 1'b0;
                state <= RUN;
            end else if (tick && state == RUN) begin
                if (!at_term) begin
                    q <= q_next;
                    if (reach_term) begin
                        tc <= 1'b1;
                        if (mode == MODE_ONESHOT) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end else if (mode == MODE_ONESHOT) begin
                    state <= DONE;
                    done  <= 1'b1;
                end else if (mode != MODE_SAT) begin
                    // Down wrap lands on max_val (a terminal write); up wrap
                    // lands on 0, which is terminal only when max_val is 0.
                    q   <= dir ? max_val : '0;
                    ovf <= 1'b1;
                    tc  <= dir ? 1'b1 : (max_val == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
module tb_param_updown_counter;

    localparam int W = 4;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         reset, en, dir, load;
    logic [1:0]   mode;
    logic [W-1:0] load_val, max_val, q;
    logic [P-1:0] pre_div;
    logic         tc, done, ovf;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int mq, mpre;
    bit mtc, mdone, movf;

    typedef struct {
        string    tag;
        bit       rst, en, dir, load;
        int       mode, lv, mx, pd;
        int       eq;
        bit       etc, edone, eovf;
    } vec_t;

    vec_t vt[$];

    always #5 clk = ~clk;

    param_updown_counter #(
        .WIDTH (W),
        .PRE_W (P)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .max_val  (max_val),
        .pre_div  (pre_div),
        .q        (q),
        .tc       (tc),
        .done     (done),
        .ovf      (ovf)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Next-state rules applied to the inputs present at the clock edge.
    task automatic model_step();
        int mx, lv, pd, target;
        bit tk, at_end;
        mx = int'(max_val);
        lv = int'(load_val);
        pd = int'(pre_div);
        if (reset) begin
            mq = 0; mpre = 0; mtc = 0; mdone = 0; movf = 0;
        end else if (load) begin
            mq = (lv > mx) ? mx : lv;
            mpre = 0; movf = 0; mdone = 0; mtc = 0;
        end else begin
            tk  = en && (mpre == pd);
            mtc = 0;
            if (en) mpre = tk ? 0 : (mpre + 1) % (1 << P);
            if (tk && !mdone) begin
                target = dir ? 0 : mx;
                at_end = dir ? (mq == 0) : (mq >= mx);
                if (!at_end) begin
                    mq = dir ? mq - 1 : mq + 1;
                    if (mq == target) begin
                        mtc = 1;
                        if (mode == 2) mdone = 1;
                    end
                end else if (mode == 2) begin
                    mdone = 1;
                end else if (mode != 1) begin
                    mq   = dir ? mx : 0;
                    movf = 1;
                    mtc  = dir || (mq == target);
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("model.q",    int'(q),    mq);
        chk("model.tc",   int'(tc),   int'(mtc));
        chk("model.done", int'(done), int'(mdone));
        chk("model.ovf",  int'(ovf),  int'(movf));
    endtask

    function automatic vec_t mk(string tag, bit rst, bit e, bit d, bit ld, int md,
                                int lv, int mx, int pd, int eq, bit etc, bit edone, bit eovf);
        vec_t r;
        r.tag = tag; r.rst = rst; r.en = e; r.dir = d; r.load = ld; r.mode = md;
        r.lv = lv; r.mx = mx; r.pd = pd; r.eq = eq; r.etc = etc; r.edone = edone; r.eovf = eovf;
        return r;
    endfunction

    initial begin
        reset = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; mode = 2'b00;
        load_val = '0; max_val = '0; pre_div = '0;
        mq = 0; mpre = 0; mtc = 0; mdone = 0; movf = 0;

        // WRAP up 0..9,0 from reset
        vt.push_back(mk("reset", 1,0,0,0,0, 0,9,0, 0,0,0,0));
        for (int i = 1; i <= 11; i++)
            vt.push_back(mk("wrap_up", 0,1,0,0,0, 0,9,0, i % 10, i == 9, 0, i >= 10));
        // load clipping and load-over-tick
        vt.push_back(mk("load_clip",  0,0,0,1,0, 12,9,0, 9,0,0,0));
        vt.push_back(mk("load_tick",  0,1,0,1,0, 3,9,0,  3,0,0,0));
        vt.push_back(mk("after_load", 0,1,0,0,0, 3,9,0,  4,0,0,0));
        // down SAT from 3
        vt.push_back(mk("dsat_load", 0,0,1,1,1, 3,9,0, 3,0,0,0));
        vt.push_back(mk("dsat",      0,1,1,0,1, 3,9,0, 2,0,0,0));
        vt.push_back(mk("dsat",      0,1,1,0,1, 3,9,0, 1,0,0,0));
        vt.push_back(mk("dsat",      0,1,1,0,1, 3,9,0, 0,1,0,0));
        vt.push_back(mk("dsat_hold", 0,1,1,0,1, 3,9,0, 0,0,0,0));
        vt.push_back(mk("dsat_hold", 0,1,1,0,1, 3,9,0, 0,0,0,0));
        // ONESHOT up to 5, mode change in DONE, reload
        vt.push_back(mk("os_load", 0,0,0,1,2, 0,5,0, 0,0,0,0));
        for (int i = 1; i <= 5; i++)
            vt.push_back(mk("os_up", 0,1,0,0,2, 0,5,0, i, i == 5, i == 5, 0));
        vt.push_back(mk("os_done",   0,1,0,0,2, 0,5,0, 5,0,1,0));
        vt.push_back(mk("os_done",   0,1,0,0,2, 0,5,0, 5,0,1,0));
        vt.push_back(mk("os_modechg",0,1,0,0,0, 0,5,0, 5,0,1,0));
        vt.push_back(mk("os_reload", 0,1,0,1,2, 2,5,0, 2,0,0,0));
        vt.push_back(mk("os_resume", 0,1,0,0,2, 2,5,0, 3,0,0,0));
        // max_val lowered below q
        vt.push_back(mk("lower_ld",   0,0,0,1,0, 8,15,0, 8,0,0,0));
        vt.push_back(mk("lower_up",   0,1,0,0,0, 8,5,0,  0,0,0,1));
        vt.push_back(mk("lower_ld2",  0,0,1,1,0, 8,15,0, 8,0,0,0));
        vt.push_back(mk("lower_down", 0,1,1,0,0, 8,5,0,  7,0,0,0));
        // max_val = 0
        vt.push_back(mk("max0_ld",   0,0,0,1,0, 5,0,0, 0,0,0,0));
        vt.push_back(mk("max0_up",   0,1,0,0,0, 5,0,0, 0,1,0,1));
        vt.push_back(mk("max0_down", 0,1,1,0,0, 5,0,0, 0,1,0,1));
        // reset mid-ONESHOT with ovf set
        vt.push_back(mk("rst_ld",   0,0,0,1,0, 9,9,0, 9,0,0,0));
        vt.push_back(mk("rst_wrap", 0,1,0,0,0, 9,9,0, 0,0,0,1));
        for (int i = 1; i <= 7; i++)
            vt.push_back(mk("rst_os", 0,1,0,0,2, 9,9,0, i,0,0,1));
        vt.push_back(mk("rst_mid",   1,1,0,0,2, 9,9,0, 0,0,0,0));
        vt.push_back(mk("rst_after", 0,1,0,0,2, 9,9,0, 1,0,0,0));
        // prescaler pre_div=2, en low 2 cycles mid-period
        vt.push_back(mk("pre_rst", 1,0,0,0,0, 0,15,2, 0,0,0,0));
        begin
            bit en_pat[9] = '{1,1,1,1,0,0,1,1,1};
            int q_pat[9]  = '{0,0,1,1,1,1,1,2,2};
            for (int i = 0; i < 9; i++)
                vt.push_back(mk("prescale", 0,en_pat[i],0,0,0, 0,15,2, q_pat[i],0,0,0));
        end

        foreach (vt[i]) begin
            reset    = vt[i].rst;
            en       = vt[i].en;
            dir      = vt[i].dir;
            load     = vt[i].load;
            mode     = 2'(vt[i].mode);
            load_val = W'(vt[i].lv);
            max_val  = W'(vt[i].mx);
            pre_div  = P'(vt[i].pd);
            cycle();
            chk({vt[i].tag, ".q"},    int'(q),    vt[i].eq);
            chk({vt[i].tag, ".tc"},   int'(tc),   int'(vt[i].etc));
            chk({vt[i].tag, ".done"}, int'(done), int'(vt[i].edone));
            chk({vt[i].tag, ".ovf"},  int'(ovf),  int'(vt[i].eovf));
        end

        // Randomised run against the reference model
        reset = 1'b1; load = 1'b0; en = 1'b0;
        max_val = 4'd9; pre_div = '0;
        cycle();
        for (int n = 0; n < 4000; n++) begin
            reset    = ($urandom_range(0, 63) == 0);
            load     = ($urandom_range(0, 15) == 0);
            en       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) dir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            load_val = W'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) max_val = W'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) pre_div = P'($urandom_range(0, 3));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning counter width in bits (2..32).
REQ-002 SHALL provide parameter PRE_W, default 4, meaning prescaler divisor width in bits (1..16).
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  count enable; gates prescaler.
REQ-006 SHALL have port dir  input  1  direction: 0 up, 1 down.
REQ-007 SHALL have port mode  input  2  00 WRAP, 01 SAT, 10 ONESHOT, 11 treated as WRAP.
REQ-008 SHALL have port load  input  1  synchronous load strobe.
REQ-009 SHALL have port load_val  input  WIDTH  value loaded on load.
REQ-010 SHALL have port max_val  input  WIDTH  up-count terminal value (modulus minus 1).
REQ-011 SHALL have port pre_div  input  PRE_W  tick every pre_div+1 enabled cycles.
REQ-012 SHALL have port q  output  WIDTH  registered count.
REQ-013 SHALL have port tc  output  1  one-cycle terminal-count pulse.
REQ-014 SHALL have port done  output  1  ONESHOT completion, level.
REQ-015 SHALL have port ovf  output  1  sticky wrap flag.

Function
REQ-016 Priority SHALL be reset > load > tick step.
REQ-017 Prescaler: pre_cnt increments on cycles with en=1; when pre_cnt==pre_div, tick=1 that cycle and pre_cnt<=0; en=0 holds pre_cnt; pre_div=0 gives tick on every enabled cycle.
REQ-018 Step SHALL occur only on a tick cycle with FSM in RUN; q updated at that edge (one-cycle latency from tick).
REQ-019 Terminal SHALL be q>=max_val for up, q==0 for down; dir/mode/max_val sampled on each tick cycle.
REQ-020 Non-terminal step: q<=q+1 (up) or q-1 (down), no other effect.
REQ-021 WRAP at terminal: q<=0 (up) or max_val (down); ovf<=1.
REQ-022 SAT at terminal: q holds; no ovf.
REQ-023 ONESHOT: step reaching terminal SHALL move FSM RUN->DONE, done<=1; in DONE no steps occur until load or reset.
REQ-024 tc SHALL be 1 for exactly the one cycle after any edge where q was written with the terminal value by a step or wrap-to-terminal (down WRAP writes max_val: tc=1); not asserted by load or reset, not re-asserted while holding in SAT.
REQ-025 Load: q<=min(load_val,max_val), pre_cnt<=0, ovf<=0, done<=0, FSM<=RUN; load overrides a coincident tick.
REQ-026 max_val lowered below q at runtime: next up tick treated as terminal; next down tick decrements normally.
REQ-027 max_val=0: up and down ticks both terminal; q stays 0 (WRAP sets ovf each tick).
REQ-028 mode change in DONE SHALL not leave DONE; only load/reset exit.

Reset
REQ-029 On reset=1 at a clock edge: q=0, pre_cnt=0, tc=0, done=0, ovf=0, FSM=RUN.
REQ-030 Reset mid-count or mid-ONESHOT SHALL abandon state fully; first tick after release steps from 0.
REQ-031 All outputs SHALL be driven from flops; no asynchronous paths.

Structure
REQ-032 Package param_counter_pkg SHALL hold mode encoding constants (MODE_WRAP, MODE_SAT, MODE_ONESHOT) and FSM state enum (RUN, DONE).
REQ-033 Prescaler SHALL be a sub-module cnt_prescaler (params PRE_W; ports clk, reset, en, clr, pre_div, tick).
REQ-034 Count/terminal logic and FSM SHALL live in param_updown_counter.

Verification
REQ-035 WIDTH=4, max_val=9, pre_div=0, up, WRAP, en=1 from reset -> q 0..9,0; tc pulse with q=9; ovf=1 after 9->0.
REQ-036 pre_div=2, up, max_val=15, en=1 -> q increments every 3rd cycle; en low 2 cycles mid-period -> period stretches by 2.
REQ-037 Down SAT, load_val=3 -> q 3,2,1,0,0...; tc single pulse at q=0; ovf stays 0.
REQ-038 ONESHOT up max_val=5 -> q stops at 5, done=1, further ticks no change; load_val=2 -> done=0, counting resumes from 2.
REQ-039 load_val=12 with max_val=9 -> q=9; load coincident with tick -> loaded value wins, no step.
REQ-040 reset asserted at q=7 in ONESHOT with ovf=1 -> next cycle q=0, ovf=0, done=0, tc=0.
